dcache_miss_ctrl: RTL and testbench

DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_timeout_cnt.sv | 27 ++
 rtl/dcache_miss_ctrl.sv | 117 +++++++++++
 tb/tb_dcache_miss_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding, line geometry and address helper for the dcache miss controller
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RD   = 2'd2,
        ST_FILL = 2'd3
    } state_t;

    localparam int LINE_W_DEF = 128;
    localparam int LINE_OFS_W = 4;
    localparam logic [31:0] LINE_OFS_MASK = (32'd1 << LINE_OFS_W) - 32'd1;

    // Clear the byte offset so every address leaving the block names a whole line
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~LINE_OFS_MASK;
    endfunction

endpackage

// File: rtl/dcache_timeout_cnt.sv
// rtl/dcache_timeout_cnt.sv - watchdog counter for the memory-side wait states of the miss controller
module dcache_timeout_cnt #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Counts waiting cycles; cleared whenever the controller is about to enter a new state
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - dcache miss FSM (writeback, line read, fill); watchdog enabled by DCACHE_TIMEOUT_EN
module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int LINE_W      = LINE_W_DEF,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req_i,
    input  logic [31:0]       miss_addr_i,
    input  logic              victim_dirty_i,
    input  logic [31:0]       victim_addr_i,
    input  logic [LINE_W-1:0] victim_data_i,
    output logic              busy_o,
    output logic              fill_valid_o,
    output logic [31:0]       fill_addr_o,
    output logic [LINE_W-1:0] fill_data_o,
    output logic              err_o,
    output logic              Dcache_rd_req_o,
    output logic [31:0]       Dcache_rd_addr_o,
    output logic              Dcache_wb_req_o,
    output logic [31:0]       Dcache_wb_addr_o,
    output logic [LINE_W-1:0] Dcache_wb_data_o,
    input  logic [LINE_W-1:0] ram_data_i,
    input  logic              ram_ready_i
);

    state_t            state_q, state_d;
    logic              tmo;
    logic              busy_q, fill_valid_q, err_q, rd_req_q, wb_req_q;
    logic [31:0]       rd_addr_q, wb_addr_q;
    logic [LINE_W-1:0] wb_data_q, fill_data_q;

    // A ram handshake only counts once the request is actually visible on the port
    logic wb_ack, rd_ack;
    assign wb_ack = (state_q == ST_WB) && wb_req_q && ram_ready_i;
    assign rd_ack = (state_q == ST_RD) && rd_req_q && ram_ready_i;

`ifdef DCACHE_TIMEOUT_EN
    dcache_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_d != state_q),
        .en      ((state_q == ST_WB) || (state_q == ST_RD)),
        .expired (tmo)
    );
`else
    // The watchdog parameter stays on the interface so both builds share one port map
    localparam logic TMO_PRESENT = (TIMEOUT_CYC < 0);
    assign tmo = TMO_PRESENT;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: memory acks advance the sequence, a watchdog expiry abandons it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (miss_req_i) state_d = victim_dirty_i ? ST_WB : ST_RD;
            ST_WB:   if (wb_ack) state_d = ST_RD;   else if (tmo) state_d = ST_IDLE;
            ST_RD:   if (rd_ack) state_d = ST_FILL; else if (tmo) state_d = ST_IDLE;
            ST_FILL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs: requests rise the cycle after state entry and drop on the ack edge
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= 1'b0;
            fill_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rd_req_q     <= 1'b0;
            wb_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            fill_data_q  <= '0;
        end else begin
            busy_q       <= (state_d != ST_IDLE);
            fill_valid_q <= (state_q == ST_FILL);
            err_q        <= tmo && !wb_ack && !rd_ack;
            wb_req_q     <= (state_q == ST_WB) && (state_d == ST_WB);
            rd_req_q     <= (state_q == ST_RD) && (state_d == ST_RD);
            if ((state_q == ST_IDLE) && miss_req_i) begin
                rd_addr_q <= line_align(miss_addr_i);
                wb_addr_q <= line_align(victim_addr_i);
                wb_data_q <= victim_data_i;
            end
            if (rd_ack) begin
                fill_data_q <= ram_data_i;
            end
        end
    end

    assign busy_o           = busy_q;
    assign fill_valid_o     = fill_valid_q;
    assign fill_addr_o      = rd_addr_q;
    assign fill_data_o      = fill_data_q;
    assign err_o            = err_q;
    assign Dcache_rd_req_o  = rd_req_q;
    assign Dcache_rd_addr_o = rd_addr_q;
    assign Dcache_wb_req_o  = wb_req_q;
    assign Dcache_wb_addr_o = wb_addr_q;
    assign Dcache_wb_data_o = wb_data_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb/tb_dcache_miss_ctrl.sv - directed self-checking bench for dcache_miss_ctrl
module tb_dcache_miss_ctrl;

    localparam int LW = 128;
    localparam logic [LW-1:0] PAT_A5  = {16{8'hA5}};
    localparam logic [LW-1:0] PAT_VIC = 128'h112233445566778899AABBCCDDEEFF00;
    localparam logic [LW-1:0] PAT_RD  = 128'hCAFE0000_DEAD0001_BEEF0002_F00D0003;
    localparam logic [LW-1:0] PAT_Z   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_req_i;
    logic [31:0]   miss_addr_i;
    logic          victim_dirty_i;
    logic [31:0]   victim_addr_i;
    logic [LW-1:0] victim_data_i;
    logic          busy_o, fill_valid_o, err_o;
    logic [31:0]   fill_addr_o;
    logic [LW-1:0] fill_data_o;
    logic          Dcache_rd_req_o, Dcache_wb_req_o;
    logic [31:0]   Dcache_rd_addr_o, Dcache_wb_addr_o;
    logic [LW-1:0] Dcache_wb_data_o;
    logic [LW-1:0] ram_data_i;
    logic          ram_ready_i;

    int checks = 0;
    int errors = 0;
    int fill_cnt = 0, err_cnt = 0, both_cnt = 0, wb_cyc = 0, rd_cyc = 0;

    dcache_miss_ctrl #(.LINE_W(LW), .TIMEOUT_CYC(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_req_i       (miss_req_i),
        .miss_addr_i      (miss_addr_i),
        .victim_dirty_i   (victim_dirty_i),
        .victim_addr_i    (victim_addr_i),
        .victim_data_i    (victim_data_i),
        .busy_o           (busy_o),
        .fill_valid_o     (fill_valid_o),
        .fill_addr_o      (fill_addr_o),
        .fill_data_o      (fill_data_o),
        .err_o            (err_o),
        .Dcache_rd_req_o  (Dcache_rd_req_o),
        .Dcache_rd_addr_o (Dcache_rd_addr_o),
        .Dcache_wb_req_o  (Dcache_wb_req_o),
        .Dcache_wb_addr_o (Dcache_wb_addr_o),
        .Dcache_wb_data_o (Dcache_wb_data_o),
        .ram_data_i       (ram_data_i),
        .ram_ready_i      (ram_ready_i)
    );

    always #5 clk = ~clk;

    // Mid-cycle event counters
    always @(negedge clk) begin
        if (fill_valid_o === 1'b1) fill_cnt++;
        if (err_o === 1'b1) err_cnt++;
        if (Dcache_rd_req_o === 1'b1 && Dcache_wb_req_o === 1'b1) both_cnt++;
        if (Dcache_wb_req_o === 1'b1) wb_cyc++;
        if (Dcache_rd_req_o === 1'b1) rd_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] addr, input logic dirty,
                              input logic [31:0] vaddr, input logic [LW-1:0] vdata);
        miss_req_i = 1'b1; miss_addr_i = addr; victim_dirty_i = dirty;
        victim_addr_i = vaddr; victim_data_i = vdata;
        tick();
        miss_req_i = 1'b0; miss_addr_i = 32'hFFFF_FFFF; victim_dirty_i = 1'b0;
        victim_addr_i = 32'hFFFF_FFFF; victim_data_i = '1;
    endtask

    task automatic test_reset();
        rst = 1'b1; miss_req_i = 1'b0; miss_addr_i = '0; victim_dirty_i = 1'b0;
        victim_addr_i = '0; victim_data_i = '0; ram_data_i = '0; ram_ready_i = 1'b0;
        tick(); tick();
        checks++; if ({busy_o, fill_valid_o, err_o, Dcache_rd_req_o, Dcache_wb_req_o} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b want 00000", {busy_o, fill_valid_o, err_o, Dcache_rd_req_o, Dcache_wb_req_o}); end
        checks++; if ({Dcache_rd_addr_o, Dcache_wb_addr_o, fill_addr_o} !== 96'h0) begin errors++; $display("FAIL reset_addr got %h %h %h want 0", Dcache_rd_addr_o, Dcache_wb_addr_o, fill_addr_o); end
        checks++; if ({Dcache_wb_data_o, fill_data_o} !== 256'h0) begin errors++; $display("FAIL reset_data got %h %h want 0", Dcache_wb_data_o, fill_data_o); end
        rst = 1'b0;
        // ram_ready_i in IDLE must not start anything
        ram_ready_i = 1'b1; tick(); tick(); ram_ready_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || fill_cnt !== 0) begin errors++; $display("FAIL idle_ready busy %b fills %0d want 0 0", busy_o, fill_cnt); end
    endtask

    task automatic test_clean_miss();
        int f0 = fill_cnt, w0 = wb_cyc;
        start_miss(32'h0000_1234, 1'b0, 32'h0, '0);
        checks++; if (busy_o !== 1'b1 || Dcache_rd_req_o !== 1'b0) begin errors++; $display("FAIL clean_entry busy %b rd_req %b want 1 0", busy_o, Dcache_rd_req_o); end
        tick();
        checks++; if (Dcache_rd_req_o !== 1'b1 || Dcache_rd_addr_o !== 32'h0000_1230) begin errors++; $display("FAIL clean_rd req %b addr %h want 1 00001230", Dcache_rd_req_o, Dcache_rd_addr_o); end
        tick(); tick();
        checks++; if (Dcache_rd_req_o !== 1'b1 || Dcache_rd_addr_o !== 32'h0000_1230) begin errors++; $display("FAIL clean_hold req %b addr %h want 1 00001230", Dcache_rd_req_o, Dcache_rd_addr_o); end
        ram_ready_i = 1'b1; ram_data_i = PAT_A5;
        tick();
        ram_data_i = PAT_RD;
        checks++; if (Dcache_rd_req_o !== 1'b0 || fill_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL clean_ack rd %b fv %b busy %b want 0 0 1", Dcache_rd_req_o, fill_valid_o, busy_o); end
        // ready held through FILL must be ignored
        tick();
        ram_ready_i = 1'b0;
        checks++; if (fill_valid_o !== 1'b1 || fill_data_o !== PAT_A5 || fill_addr_o !== 32'h0000_1230) begin errors++; $display("FAIL clean_fill fv %b data %h addr %h want 1 %h 00001230", fill_valid_o, fill_data_o, fill_addr_o, PAT_A5); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL clean_busy got %b want 0", busy_o); end
        tick(); tick();
        checks++; if (fill_cnt - f0 !== 1 || wb_cyc - w0 !== 0 || fill_valid_o !== 1'b0) begin errors++; $display("FAIL clean_count fills %0d wb %0d fv %b want 1 0 0", fill_cnt - f0, wb_cyc - w0, fill_valid_o); end
    endtask

    task automatic test_dirty_miss();
        int f0 = fill_cnt;
        start_miss(32'h0000_3000, 1'b1, 32'h0000_2010, PAT_VIC);
        checks++; if (Dcache_wb_req_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL dirty_entry wb %b busy %b want 0 1", Dcache_wb_req_o, busy_o); end
        tick(); tick();
        checks++; if (Dcache_wb_req_o !== 1'b1 || Dcache_wb_addr_o !== 32'h0000_2010 || Dcache_wb_data_o !== PAT_VIC || Dcache_rd_req_o !== 1'b0) begin errors++; $display("FAIL dirty_wb wb %b addr %h data %h rd %b want 1 00002010 %h 0", Dcache_wb_req_o, Dcache_wb_addr_o, Dcache_wb_data_o, Dcache_rd_req_o, PAT_VIC); end
        ram_ready_i = 1'b1;
        tick();
        ram_ready_i = 1'b0;
        checks++; if (Dcache_wb_req_o !== 1'b0 || Dcache_rd_req_o !== 1'b0) begin errors++; $display("FAIL dirty_wback wb %b rd %b want 0 0", Dcache_wb_req_o, Dcache_rd_req_o); end
        tick();
        checks++; if (Dcache_rd_req_o !== 1'b1 || Dcache_rd_addr_o !== 32'h0000_3000) begin errors++; $display("FAIL dirty_rd rd %b addr %h want 1 00003000", Dcache_rd_req_o, Dcache_rd_addr_o); end
        ram_ready_i = 1'b1; ram_data_i = PAT_RD;
        tick();
        ram_ready_i = 1'b0;
        tick();
        checks++; if (fill_valid_o !== 1'b1 || fill_data_o !== PAT_RD || fill_addr_o !== 32'h0000_3000) begin errors++; $display("FAIL dirty_fill fv %b data %h addr %h want 1 %h 00003000", fill_valid_o, fill_data_o, fill_addr_o, PAT_RD); end
        tick();
        checks++; if (fill_cnt - f0 !== 1) begin errors++; $display("FAIL dirty_count fills %0d want 1", fill_cnt - f0); end
    endtask

    task automatic test_zero_wait();
        int f0 = fill_cnt, w0 = wb_cyc, r0 = rd_cyc;
        start_miss(32'h0000_ABCD, 1'b1, 32'h0000_777F, PAT_A5);
        tick();
        ram_ready_i = 1'b1;  // first wb_req cycle
        tick();
        ram_ready_i = 1'b0;
        tick();
        checks++; if (Dcache_rd_req_o !== 1'b1 || Dcache_rd_addr_o !== 32'h0000_ABC0) begin errors++; $display("FAIL zw_rd rd %b addr %h want 1 0000abc0", Dcache_rd_req_o, Dcache_rd_addr_o); end
        ram_ready_i = 1'b1; ram_data_i = PAT_Z;  // first rd_req cycle
        tick();
        ram_ready_i = 1'b0;
        checks++; if (fill_valid_o !== 1'b0) begin errors++; $display("FAIL zw_early fv %b want 0", fill_valid_o); end
        tick();
        checks++; if (fill_valid_o !== 1'b1 || fill_data_o !== PAT_Z) begin errors++; $display("FAIL zw_fill fv %b data %h want 1 %h", fill_valid_o, fill_data_o, PAT_Z); end
        tick();
        checks++; if (wb_cyc - w0 !== 1 || rd_cyc - r0 !== 1 || fill_cnt - f0 !== 1) begin errors++; $display("FAIL zw_len wb %0d rd %0d fills %0d want 1 1 1", wb_cyc - w0, rd_cyc - r0, fill_cnt - f0); end
    endtask

    task automatic test_reset_mid_rd();
        int f0 = fill_cnt;
        start_miss(32'h0000_5558, 1'b0, 32'h0000_9990, PAT_VIC);
        tick();
        checks++; if (Dcache_rd_req_o !== 1'b1) begin errors++; $display("FAIL rmid_pre rd %b want 1", Dcache_rd_req_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({busy_o, fill_valid_o, err_o, Dcache_rd_req_o, Dcache_wb_req_o} !== 5'b0 || {Dcache_rd_addr_o, Dcache_wb_addr_o, fill_addr_o} !== 96'h0 || {Dcache_wb_data_o, fill_data_o} !== 256'h0) begin errors++; $display("FAIL rmid_out ctl %b rd_addr %h wb_addr %h want all 0", {busy_o, fill_valid_o, err_o, Dcache_rd_req_o, Dcache_wb_req_o}, Dcache_rd_addr_o, Dcache_wb_addr_o); end
        ram_ready_i = 1'b1; ram_data_i = PAT_A5;
        tick(); tick(); tick();
        ram_ready_i = 1'b0;
        checks++; if (fill_cnt - f0 !== 0 || busy_o !== 1'b0) begin errors++; $display("FAIL rmid_nofill fills %0d busy %b want 0 0", fill_cnt - f0, busy_o); end
    endtask

    task automatic test_busy_ignore();
        int f0 = fill_cnt, w0 = wb_cyc;
        start_miss(32'h0000_4000, 1'b0, 32'h0, '0);
        miss_req_i = 1'b1; miss_addr_i = 32'h0000_5000; victim_dirty_i = 1'b1;
        tick();
        miss_req_i = 1'b0;
        tick();
        miss_req_i = 1'b1;
        ram_ready_i = 1'b1; ram_data_i = PAT_RD;
        tick();
        ram_ready_i = 1'b0;
        miss_req_i = 1'b0;
        tick();
        miss_req_i = 1'b1;
        checks++; if (fill_valid_o !== 1'b1 || fill_addr_o !== 32'h0000_4000) begin errors++; $display("FAIL busy_fill fv %b addr %h want 1 00004000", fill_valid_o, fill_addr_o); end
        miss_req_i = 1'b0;
        tick(); tick(); tick();
        checks++; if (fill_cnt - f0 !== 1 || wb_cyc - w0 !== 0 || busy_o !== 1'b0) begin errors++; $display("FAIL busy_count fills %0d wb %0d busy %b want 1 0 0", fill_cnt - f0, wb_cyc - w0, busy_o); end
    endtask

`ifdef DCACHE_TIMEOUT_EN
    task automatic test_timeout();
        int f0 = fill_cnt, e0 = err_cnt, r0 = rd_cyc;
        start_miss(32'h0000_6004, 1'b0, 32'h0, '0);
        for (int i = 1; i < 8; i++) tick();
        checks++; if (Dcache_rd_req_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL tmo_hold rd %b err %b want 1 0", Dcache_rd_req_o, err_o); end
        tick();
        checks++; if (Dcache_rd_req_o !== 1'b0 || err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL tmo_fire rd %b err %b busy %b want 0 1 0", Dcache_rd_req_o, err_o, busy_o); end
        tick(); tick(); tick();
        checks++; if (err_cnt - e0 !== 1 || fill_cnt - f0 !== 0 || rd_cyc - r0 !== 7) begin errors++; $display("FAIL tmo_count errs %0d fills %0d rd %0d want 1 0 7", err_cnt - e0, fill_cnt - f0, rd_cyc - r0); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_zero_wait();
        test_reset_mid_rd();
        test_busy_ignore();
`ifdef DCACHE_TIMEOUT_EN
        test_timeout();
`else
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL err_tied pulses %0d want 0", err_cnt); end
`endif
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL req_overlap cycles %0d want 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
